// File: rtl/jk_pkg.sv
// Shared JK flip-flop encodings and the characteristic next-state function.
// Latency: none, pure combinational helpers.
// Backpressure: not applicable.
package jk_pkg;

  // {J,K} input pair encodings.
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Characteristic equation of a JK flip-flop: Qnext = J&~Q | ~K&Q.
  function automatic logic jk_next(input logic j, input logic k, input logic q);
    logic r;
    case ({j, k})
      JK_HOLD:   r = q;
      JK_RESET:  r = 1'b0;
      JK_SET:    r = 1'b1;
      JK_TOGGLE: r = ~q;
      default:   r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control/status bundle of the modulo-N counter.
// Latency: none, wiring only.
// Backpressure: none; the counter accepts new controls every edge.
interface jk_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             UP;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             TC;

  // Controller side: drives controls, observes count and terminal flag.
  modport master (output EN, UP, LOAD, D, input Q, TC);
  // Counter side.
  modport slave  (input EN, UP, LOAD, D, output Q, TC);
endinterface

// File: rtl/jk_ff.sv
// Single-bit JK flip-flop, falling-edge clocked, async active-low reset.
// Latency: one falling edge from J/K to Q.
// Backpressure: none.
module jk_ff
  import jk_pkg::*;
(
  input  logic CLK,
  input  logic RST_N,
  input  logic J,
  input  logic K,
  output logic Q
);

  // State bit: cleared at once by reset, otherwise follows the JK equation.
  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= 1'b0;
    end else begin
      Q <= jk_next(J, K, Q);
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter with parallel load built from a bank of JK flip-flops.
// Latency: one falling edge from controls to Q; TC is combinational.
// Backpressure: none; LOAD > EN > hold is resolved every edge.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  jk_mod_counter_if.slave   bus
);

  // One extra bit keeps saturation compares and +/-1 free of overflow,
  // and lets MODULUS == 2**WIDTH be represented.
  localparam logic [WIDTH:0] MOD_EXT = MODULUS[WIDTH:0];
  localparam logic [WIDTH:0] MAX_EXT = MOD_EXT - {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   nxt_ext;

  assign q_ext = {1'b0, q};
  assign d_ext = {1'b0, bus.D};

  // Desired next count: saturating load, else wrap-around up/down count, else hold.
  // An out-of-range Q counting up wraps to 0 via the >= compare.
  always_comb begin
    nxt_ext = q_ext;
    if (bus.LOAD) begin
      nxt_ext = (d_ext >= MOD_EXT) ? MAX_EXT : d_ext;
    end else if (bus.EN) begin
      if (bus.UP) begin
        nxt_ext = (q_ext >= MAX_EXT) ? '0 : (q_ext + ONE_EXT);
      end else begin
        nxt_ext = (q_ext == '0) ? MAX_EXT : (q_ext - ONE_EXT);
      end
    end
  end

  // nxt_ext never exceeds MODULUS-1, so its top bit is always zero.
  assign n = WIDTH'(nxt_ext);

  // Set only bits that must rise, reset only bits that must fall; J=K=1 never occurs.
  assign j = n & ~q;
  assign k = ~n & q;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      jk_ff u_ff (
        .CLK   (CLK),
        .RST_N (RST_N),
        .J     (j[gi]),
        .K     (k[gi]),
        .Q     (q[gi])
      );
    end
  endgenerate

  assign bus.Q  = q;
  // High while the coming edge would wrap in the selected direction.
  assign bus.TC = bus.EN & ~bus.LOAD & (bus.UP ? (q_ext == MAX_EXT) : (q_ext == '0));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Self-checking bench: two counters (4-bit mod 10, 3-bit mod 5) against an arithmetic model.
// Inputs driven just after posedge, Q sampled just after the active negedge.
// Random load/enable/direction traffic on the small counter with JK pair checks.
module tb_jk_mod_counter;

  logic CLK = 1'b1;
  logic RST_N;

  always #5 CLK = ~CLK;

  jk_mod_counter_if #(.WIDTH(4)) bus_a ();
  jk_mod_counter_if #(.WIDTH(3)) bus_b ();

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_a.slave)
  );

  jk_mod_counter #(.WIDTH(3), .MODULUS(5)) dut_b (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus_b.slave)
  );

  int vectors     = 0;
  int miscompares = 0;
  int qa = 0;
  int qb = 0;

  typedef struct {
    bit ld;
    int d;
    bit en;
    bit up;
  } stim_t;

  // Reference model straight from the counting rules.
  function automatic int ref_next(int q, bit ld, int d, bit en, bit up, int m);
    if (ld) return (d >= m) ? m - 1 : d;
    if (!en) return q;
    if (up) return (q >= m - 1) ? 0 : q + 1;
    return (q == 0) ? m - 1 : q - 1;
  endfunction

  function automatic bit ref_tc(int q, bit ld, bit en, bit up, int m);
    return en && !ld && (up ? (q == m - 1) : (q == 0));
  endfunction

  task automatic apply_a(input stim_t s);
    @(posedge CLK);
    #1;
    bus_a.LOAD = s.ld;
    bus_a.D    = 4'(s.d);
    bus_a.EN   = s.en;
    bus_a.UP   = s.up;
  endtask

  task automatic apply_b(input stim_t s);
    @(posedge CLK);
    #1;
    bus_b.LOAD = s.ld;
    bus_b.D    = 3'(s.d);
    bus_b.EN   = s.en;
    bus_b.UP   = s.up;
  endtask

  task automatic after_edge();
    @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    stim_t s;
    RST_N = 1'b0;
    bus_a.LOAD = 0; bus_a.D = '0; bus_a.EN = 0; bus_a.UP = 1;
    bus_b.LOAD = 0; bus_b.D = '0; bus_b.EN = 0; bus_b.UP = 1;
    #2;
    vectors++;
    if (bus_a.Q !== 4'd0) begin miscompares++; $display("FAIL reset_qa got %0d want 0", bus_a.Q); end
    vectors++;
    if (bus_b.Q !== 3'd0) begin miscompares++; $display("FAIL reset_qb got %0d want 0", bus_b.Q); end
    vectors++;
    if (bus_a.TC !== 1'b0) begin miscompares++; $display("FAIL reset_tc got %b want 0", bus_a.TC); end
    @(posedge CLK);
    #1 RST_N = 1'b1;
    qa = 0; qb = 0;
    // Bring counter to 5: load 3, then count up twice.
    s = '{ld: 1, d: 3, en: 0, up: 1};
    apply_a(s); after_edge(); qa = ref_next(qa, s.ld, s.d, s.en, s.up, 10);
    s = '{ld: 0, d: 0, en: 1, up: 1};
    for (int i = 0; i < 2; i++) begin
      apply_a(s); after_edge(); qa = ref_next(qa, s.ld, s.d, s.en, s.up, 10);
    end
    vectors++;
    if (bus_a.Q !== 4'(qa)) begin miscompares++; $display("FAIL premid_q got %0d want %0d", bus_a.Q, qa); end
    // Assert reset between edges while counting is enabled.
    #2 RST_N = 1'b0;
    #1;
    qa = 0;
    vectors++;
    if (bus_a.Q !== 4'd0) begin miscompares++; $display("FAIL midreset_q got %0d want 0", bus_a.Q); end
    for (int i = 0; i < 2; i++) begin
      after_edge();
      vectors++;
      if (bus_a.Q !== 4'd0) begin miscompares++; $display("FAIL reset_hold_q got %0d want 0", bus_a.Q); end
      vectors++;
      if (bus_a.TC !== 1'b0) begin miscompares++; $display("FAIL reset_hold_tc got %b want 0", bus_a.TC); end
    end
    @(posedge CLK);
    #1 RST_N = 1'b1;
    bus_a.EN = 0;
    qa = 0; qb = 0;
  endtask

  task automatic test_a_sequence(input string name, input stim_t seq[$]);
    int exp;
    bit tc_exp;
    foreach (seq[i]) begin
      apply_a(seq[i]);
      #1;
      tc_exp = ref_tc(qa, seq[i].ld, seq[i].en, seq[i].up, 10);
      vectors++;
      if (bus_a.TC !== tc_exp)
        begin miscompares++; $display("FAIL %s_tc step %0d got %b want %b (q=%0d)", name, i, bus_a.TC, tc_exp, qa); end
      exp = ref_next(qa, seq[i].ld, seq[i].d, seq[i].en, seq[i].up, 10);
      after_edge();
      vectors++;
      if (bus_a.Q !== 4'(exp))
        begin miscompares++; $display("FAIL %s_q step %0d got %0d want %0d", name, i, bus_a.Q, exp); end
      qa = exp;
    end
  endtask

  task automatic test_up_wrap();
    stim_t seq[$];
    seq.push_back('{ld: 1, d: 0, en: 0, up: 0});
    for (int i = 0; i < 11; i++) seq.push_back('{ld: 0, d: $urandom_range(0, 15), en: 1, up: 1});
    test_a_sequence("up_wrap", seq);
  endtask

  task automatic test_down_wrap();
    stim_t seq[$];
    seq.push_back('{ld: 1, d: 2, en: 0, up: 1});
    for (int i = 0; i < 4; i++) seq.push_back('{ld: 0, d: $urandom_range(0, 15), en: 1, up: 0});
    test_a_sequence("down_wrap", seq);
  endtask

  task automatic test_load();
    stim_t seq[$];
    seq.push_back('{ld: 1, d: 7,  en: 1, up: 1});
    seq.push_back('{ld: 1, d: 12, en: 1, up: 0});
    seq.push_back('{ld: 1, d: 15, en: 0, up: 1});
    seq.push_back('{ld: 1, d: 9,  en: 1, up: 1});
    seq.push_back('{ld: 1, d: $urandom_range(0, 15), en: 1, up: 0});
    test_a_sequence("load", seq);
  endtask

  task automatic test_hold_dir();
    stim_t seq[$];
    seq.push_back('{ld: 1, d: 4, en: 0, up: 1});
    for (int i = 0; i < 3; i++) seq.push_back('{ld: 0, d: $urandom_range(0, 15), en: 0, up: 1'($urandom_range(0, 1))});
    seq.push_back('{ld: 0, d: 0, en: 1, up: 1});
    seq.push_back('{ld: 0, d: 0, en: 1, up: 0});
    seq.push_back('{ld: 0, d: 0, en: 1, up: 1});
    // Direction flip at the wrap value: 0 going up must give 1, not wrap.
    seq.push_back('{ld: 1, d: 0, en: 0, up: 0});
    seq.push_back('{ld: 0, d: 0, en: 1, up: 1});
    test_a_sequence("hold_dir", seq);
  endtask

  task automatic test_random_jk();
    stim_t s;
    int n;
    logic [2:0] qprev, jexp, kexp, jo, ko, qo;
    bit tc_exp;
    for (int i = 0; i < 500; i++) begin
      s.ld = ($urandom_range(0, 7) == 0);
      s.d  = $urandom_range(0, 7);
      s.en = ($urandom_range(0, 3) != 0);
      s.up = 1'($urandom_range(0, 1));
      apply_b(s);
      #1;
      n      = ref_next(qb, s.ld, s.d, s.en, s.up, 5);
      qprev  = 3'(qb);
      jexp   = 3'(n) & ~qprev;
      kexp   = ~3'(n) & qprev;
      jo     = dut_b.j;
      ko     = dut_b.k;
      tc_exp = ref_tc(qb, s.ld, s.en, s.up, 5);
      vectors++;
      if ((jo & ko) !== 3'b000) begin miscompares++; $display("FAIL jk_both edge %0d j=%b k=%b", i, jo, ko); end
      vectors++;
      if (jo !== jexp) begin miscompares++; $display("FAIL jk_j edge %0d got %b want %b", i, jo, jexp); end
      vectors++;
      if (ko !== kexp) begin miscompares++; $display("FAIL jk_k edge %0d got %b want %b", i, ko, kexp); end
      vectors++;
      if (bus_b.TC !== tc_exp) begin miscompares++; $display("FAIL rnd_tc edge %0d got %b want %b", i, bus_b.TC, tc_exp); end
      after_edge();
      qo = bus_b.Q;
      vectors++;
      if (qo !== ((qprev & ~ko) | (~qprev & jo)))
        begin miscompares++; $display("FAIL jk_eq edge %0d got %b prev %b j %b k %b", i, qo, qprev, jo, ko); end
      vectors++;
      if (qo !== 3'(n)) begin miscompares++; $display("FAIL rnd_q edge %0d got %0d want %0d", i, qo, n); end
      qb = n;
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold_dir();
    test_random_jk();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
